// File: rtl/mult_pkg.sv
// Shared definitions for the round-robin multiplier arbiter.
//   - state encodings for the arbiter FSM
//   - default operand width
//   - maximum supported requester count
package mult_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_WAIT  = WAIT,
    ST_RESP  = RESP
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int NREQ_MAX      = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req        in   NREQ       request levels
//   last_grant in   clog2      index served most recently
//   found      out  1          at least one request is pending
//   gnt_id     out  clog2      first pending request after last_grant (wrapping)
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic            found,
  output logic [IDW-1:0]  gnt_id
);

  int             idx;
  logic [IDW-1:0] cand;

  // Walk offsets from the farthest to the nearest so the nearest
  // pending requester after last_grant overwrites all others.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    cand   = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx  = (int'(last_grant) + off) % NREQ;
      cand = idx[IDW-1:0];
      if (req[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one iterative multiplier among NREQ
// requesters. A granted request has its operands latched, the multiplier
// is started, and the product (or a timeout error) is returned with a
// one-cycle ack to the granted requester.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   req, a_in, b_in         requester levels and sliced operands
//   ack, result, result_id, err   registered response (valid with ack)
//   busy                    high outside IDLE
//   mul_start, mul_a, mul_b multiplier command
//   mul_done, mul_product   multiplier completion
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    a_in,
  input  logic [NREQ*WIDTH-1:0]    b_in,
  output logic [NREQ-1:0]          ack,
  output logic [2*WIDTH-1:0]       result,
  output logic [$clog2(NREQ)-1:0]  result_id,
  output logic                     err,
  output logic                     busy,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product
);

  localparam int IDW = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WDOG_LAST = WDW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

  state_t          state;
  logic [WDW-1:0]  wdog;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  gnt_id;
  logic            found;
  logic [IDW-1:0]  pick_id;

  logic [WIDTH-1:0] a_slice [NREQ];
  logic [WIDTH-1:0] b_slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_slice[gi] = a_in[gi*WIDTH +: WIDTH];
    assign b_slice[gi] = b_in[gi*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .found      (found),
    .gnt_id     (pick_id)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ack        <= '0;
      result     <= '0;
      result_id  <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      wdog       <= '0;
      gnt_id     <= '0;
      // Pointing at the last index makes requester 0 the first choice.
      last_grant <= IDW'(NREQ - 1);
    end else begin
      // ack and mul_start are single-cycle pulses.
      ack       <= '0;
      mul_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            mul_a     <= a_slice[pick_id];
            mul_b     <= b_slice[pick_id];
            gnt_id    <= pick_id;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_done) begin
            result    <= mul_product;
            err       <= 1'b0;
            ack       <= ONE_HOT0 << gnt_id;
            result_id <= gnt_id;
            state     <= ST_RESP;
          end else if (wdog == WDOG_LAST) begin
            result    <= '0;
            err       <= 1'b1;
            ack       <= ONE_HOT0 << gnt_id;
            result_id <= gnt_id;
            state     <= ST_RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_RESP: begin
          last_grant <= gnt_id;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int TIMEOUT = 16;
  localparam int ALL_PROD [5] = '{6, 12, 20, 30, 6};
  localparam int ALL_ID   [5] = '{0, 1, 2, 3, 0};

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*WIDTH-1:0] a_in = '0;
  logic [NREQ*WIDTH-1:0] b_in = '0;
  logic [NREQ-1:0]   ack;
  logic [2*WIDTH-1:0] result;
  logic [1:0]        result_id;
  logic              err, busy, mul_start;
  logic [WIDTH-1:0]  mul_a, mul_b;
  logic              mul_done = 1'b0;
  logic [2*WIDTH-1:0] mul_product = '0;

  int errors = 0;
  int checks = 0;

  // multiplier model controls
  int         cnt = 0;
  logic       mul_en = 1'b1;
  int         mul_lat = 9;
  logic       spur = 1'b0;
  logic [7:0] pa, pb;

  mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .result(result), .result_id(result_id), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clock = ~clock;

  // Behavioural multiplier: done is raised mul_lat cycles after start.
  always @(negedge clock) begin
    if (!reset_n) begin
      cnt = 0;
      mul_done = 1'b0;
    end else begin
      mul_done = 1'b0;
      if (spur) begin
        mul_done = 1'b1;
        spur = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_done = 1'b1;
          mul_product = pa * pb;
        end
      end
      if (mul_start && mul_en) begin
        cnt = mul_lat;
        pa = mul_a;
        pb = mul_b;
      end
    end
  end

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Waits (bounded) for the next ack and reports what was observed.
  task automatic wait_ack(output int id, output int start_at, output int ack_at,
                          output int busy_low, output logic [3:0] ackv,
                          output logic [15:0] res, output logic e,
                          output int nstart, output logic [7:0] sa, output logic [7:0] sb);
    id = -1; start_at = -1; ack_at = -1; busy_low = 0; nstart = 0;
    ackv = '0; res = '0; e = 1'b0; sa = '0; sb = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (mul_start) begin
        nstart++;
        if (start_at < 0) begin
          start_at = k; sa = mul_a; sb = mul_b;
        end
      end
      if (!busy) busy_low++;
      if (ack != '0) begin
        ackv = ack; res = result; e = err; ack_at = k; id = int'(result_id);
        $display("ack id=%0d vec=%b result=%0d err=%0b cycle=%0d", id, ackv, res, e, k);
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (ack !== 4'b0 || busy !== 1'b0 || mul_start !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ack=%b busy=%b start=%b want 0", ack, busy, mul_start); end
    checks++; if (result !== 16'd0 || result_id !== 2'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_resp: result=%0d id=%0d err=%b want 0", result, result_id, err); end
    checks++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin
      errors++; $display("FAIL reset_ops: a=%0d b=%0d want 0", mul_a, mul_b); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int id, st, at, bl, ns; logic [3:0] av; logic [15:0] r; logic e; logic [7:0] sa, sb;
    mul_lat = 9;
    set_ops(2, 8'd13, 8'd11);
    req = 4'b0100;
    wait_ack(id, st, at, bl, av, r, e, ns, sa, sb);
    req = '0;
    checks++; if (av !== 4'b0100) begin errors++; $display("FAIL single_ack: %b want 0100", av); end
    checks++; if (r !== 16'd143) begin errors++; $display("FAIL single_result: %0d want 143", r); end
    checks++; if (id != 2 || e !== 1'b0) begin errors++; $display("FAIL single_id_err: id=%0d err=%b want 2/0", id, e); end
    checks++; if (st != 1 || ns != 1) begin errors++; $display("FAIL single_start: at=%0d n=%0d want 1/1", st, ns); end
    checks++; if (at != 11) begin errors++; $display("FAIL single_latency: %0d want 11", at); end
    checks++; if (sa !== 8'd13 || sb !== 8'd11) begin errors++; $display("FAIL single_ops: %0d,%0d want 13,11", sa, sb); end
    @(negedge clock);
    checks++; if (ack !== 4'b0 || result !== 16'd143) begin
      errors++; $display("FAIL single_hold: ack=%b result=%0d want 0000/143", ack, result); end
  endtask

  task automatic test_all_four();
    int id, st, at, bl, ns; logic [3:0] av; logic [15:0] r; logic e; logic [7:0] sa, sb;
    do_reset();
    mul_lat = 9;
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 2), 8'(i + 3));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(id, st, at, bl, av, r, e, ns, sa, sb);
      checks++; if (id != ALL_ID[n] || av !== (4'b0001 << ALL_ID[n])) begin
        errors++; $display("FAIL rr4_order[%0d]: id=%0d vec=%b want %0d", n, id, av, ALL_ID[n]); end
      checks++; if (r !== 16'(ALL_PROD[n])) begin
        errors++; $display("FAIL rr4_result[%0d]: %0d want %0d", n, r, ALL_PROD[n]); end
      checks++; if (bl != ((n == 0) ? 0 : 1)) begin
        errors++; $display("FAIL rr4_busy[%0d]: idle cycles %0d want %0d", n, bl, (n == 0) ? 0 : 1); end
    end
    req = '0;
  endtask

  task automatic test_alternate();
    int id, st, at, bl, ns, prev; logic [3:0] av; logic [15:0] r; logic e; logic [7:0] sa, sb;
    do_reset();
    mul_lat = 4;
    set_ops(0, 8'd5, 8'd7);
    set_ops(3, 8'd9, 8'd10);
    req = 4'b1001;
    prev = -1;
    for (int n = 0; n < 4; n++) begin
      wait_ack(id, st, at, bl, av, r, e, ns, sa, sb);
      checks++; if (id != ((n % 2 == 0) ? 0 : 3) || id == prev) begin
        errors++; $display("FAIL alt_order[%0d]: id=%0d prev=%0d want %0d", n, id, prev, (n % 2 == 0) ? 0 : 3); end
      checks++; if (r !== ((n % 2 == 0) ? 16'd35 : 16'd90)) begin
        errors++; $display("FAIL alt_result[%0d]: %0d want %0d", n, r, (n % 2 == 0) ? 35 : 90); end
      prev = id;
    end
    req = '0;
  endtask

  task automatic test_timeout();
    int id, st, at, bl, ns; logic [3:0] av; logic [15:0] r; logic e; logic [7:0] sa, sb;
    do_reset();
    mul_en = 1'b0;
    set_ops(1, 8'd3, 8'd4);
    req = 4'b0010;
    wait_ack(id, st, at, bl, av, r, e, ns, sa, sb);
    checks++; if (av !== 4'b0010 || e !== 1'b1 || r !== 16'd0) begin
      errors++; $display("FAIL tmo_resp: vec=%b err=%b result=%0d want 0010/1/0", av, e, r); end
    checks++; if (st < 0 || at - st != 17) begin
      errors++; $display("FAIL tmo_latency: start=%0d ack=%0d want gap 17", st, at); end
    // requester keeps req high for a fresh operation that completes
    mul_en = 1'b1;
    mul_lat = 3;
    set_ops(1, 8'd6, 8'd7);
    wait_ack(id, st, at, bl, av, r, e, ns, sa, sb);
    req = '0;
    checks++; if (id != 1 || e !== 1'b0 || r !== 16'd42) begin
      errors++; $display("FAIL tmo_recover: id=%0d err=%b result=%0d want 1/0/42", id, e, r); end
    checks++; if (at != 6) begin errors++; $display("FAIL tmo_relatency: %0d want 6", at); end
  endtask

  task automatic test_reset_mid();
    int id, st, at, bl, ns, seen; logic [3:0] av; logic [15:0] r; logic e; logic [7:0] sa, sb;
    mul_lat = 3;
    set_ops(0, 8'd2, 8'd9);
    req = 4'b0001;
    wait_ack(id, st, at, bl, av, r, e, ns, sa, sb);
    checks++; if (id != 0 || r !== 16'd18) begin
      errors++; $display("FAIL rmid_pre: id=%0d result=%0d want 0/18", id, r); end
    mul_lat = 9;
    req = 4'b0010;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clock);
      if (mul_start) seen = 1;
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL rmid_start: no start seen want 1"); end
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    req = '0;
    #1;
    checks++; if (busy !== 1'b0 || ack !== 4'b0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
      errors++; $display("FAIL rmid_clear: busy=%b ack=%b a=%0d b=%0d want 0", busy, ack, mul_a, mul_b); end
    checks++; if (result !== 16'd0 || result_id !== 2'd0 || err !== 1'b0) begin
      errors++; $display("FAIL rmid_resp: result=%0d id=%0d err=%b want 0", result, result_id, err); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    req = 4'b0011;
    wait_ack(id, st, at, bl, av, r, e, ns, sa, sb);
    req = '0;
    checks++; if (id != 0 || r !== 16'd18) begin
      errors++; $display("FAIL rmid_regrant: id=%0d result=%0d want 0/18", id, r); end
  endtask

  task automatic test_boundary();
    int id, st, at, bl, ns, bad; logic [3:0] av; logic [15:0] r; logic e; logic [7:0] sa, sb;
    do_reset();
    mul_lat = 2;
    set_ops(0, 8'd255, 8'd255);
    req = 4'b0001;
    wait_ack(id, st, at, bl, av, r, e, ns, sa, sb);
    req = '0;
    checks++; if (r !== 16'hFE01 || e !== 1'b0 || id != 0) begin
      errors++; $display("FAIL max_result: %h err=%b id=%0d want fe01/0/0", r, e, id); end
    @(negedge clock);
    mul_product = 16'h1234;
    spur = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (ack !== 4'b0 || busy !== 1'b0 || mul_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL spur_idle: %0d active cycles want 0", bad); end
    checks++; if (result !== 16'hFE01) begin errors++; $display("FAIL spur_hold: %h want fe01", result); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
